// File: rtl/lvdc_pio_pkg.sv
// Shared constants and FSM state types for the PIO-mapped UART peripheral.
package lvdc_pio_pkg;

    localparam logic [1:0] OFS_TXDATA = 2'd0;
    localparam logic [1:0] OFS_RXDATA = 2'd1;
    localparam logic [1:0] OFS_STATUS = 2'd2;
    localparam logic [1:0] OFS_CTRL   = 2'd3;

    localparam int ST_RXNE    = 0;
    localparam int ST_RXFULL  = 1;
    localparam int ST_TXFULL  = 2;
    localparam int ST_TXEMPTY = 3;
    localparam int ST_TXBUSY  = 4;
    localparam int ST_RXOVF   = 5;
    localparam int ST_TXOVF   = 6;
    localparam int ST_FE_ANY  = 7;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/lvdc_byte_fifo.sv
// Small first-word-fall-through FIFO; pointers carry one extra wrap bit.
module lvdc_byte_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    // A pop in the same cycle frees the slot a push on a full FIFO needs.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg[AW-1:0]] <= din;
    end

    assign dout = mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/lvdc_pio_uart.sv
// PIO-mapped 8N1 UART: strobe decode, TX/RX byte FIFOs, serial FSMs and IRQ.
module lvdc_pio_uart
    import lvdc_pio_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR    = 8'h40,
    parameter int         CLKS_PER_BIT = 16,
    parameter int         FIFO_DEPTH   = 8
) (
    input  logic        CLK,
    input  logic        RST,
    inout  wire  [25:0] DB,
    input  logic [12:0] I,
    input  logic        nIOR,
    input  logic        nIOW,
    input  logic        RXD,
    output logic        TXD,
    output logic        IRQ
);
    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic [7:0]  addr_diff;
    logic        addr_hit;
    logic [1:0]  reg_ofs;
    logic        nior_reg, niow_reg;
    logic        wr_fire, rd_done, tx_wr, ctrl_wr, rx_rd, st_rd;
    logic        rxie_reg, txie_reg, irq_reg;
    logic [7:0]  status;
    logic [25:0] rd_data;
    logic [2:0]  sticky_set, sticky_bits;
    logic        unused_bits;

    logic [7:0]  tx_dout;
    logic        tx_full, tx_empty, tx_pop, tx_busy, tx_tick, txd;
    tx_state_t   tx_state_reg, tx_state_next;
    logic [CW-1:0] tx_cnt_reg;
    logic [2:0]  tx_bit_reg;
    logic [7:0]  tx_shift_reg;

    logic [8:0]  rx_din, rx_dout;
    logic        rx_full, rx_empty, rx_push, rx_tick, rx_half;
    logic        rx_meta_reg, rx_sync_reg, rx_prev_reg;
    rx_state_t   rx_state_reg, rx_state_next;
    logic [CW-1:0] rx_cnt_reg;
    logic [2:0]  rx_bit_reg;
    logic [7:0]  rx_shift_reg;

    // Subtracting the base lets any BASE_ADDR alignment work.
    assign addr_diff = I[7:0] - BASE_ADDR;
    assign addr_hit  = (addr_diff[7:2] == 6'd0);
    assign reg_ofs   = addr_diff[1:0];

    assign wr_fire = niow_reg & ~nIOW & addr_hit;
    assign rd_done = ~nior_reg & nIOR & addr_hit;
    assign tx_wr   = wr_fire && (reg_ofs == OFS_TXDATA);
    assign ctrl_wr = wr_fire && (reg_ofs == OFS_CTRL);
    assign rx_rd   = rd_done && (reg_ofs == OFS_RXDATA);
    assign st_rd   = rd_done && (reg_ofs == OFS_STATUS);

    assign unused_bits = ^{DB[25:8], I[12:8]};

    always_ff @(posedge CLK) begin
        if (RST) begin
            nior_reg    <= 1'b1;
            niow_reg    <= 1'b1;
            rxie_reg    <= 1'b0;
            txie_reg    <= 1'b0;
            irq_reg     <= 1'b0;
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
            rx_prev_reg <= 1'b1;
        end else begin
            nior_reg    <= nIOR;
            niow_reg    <= nIOW;
            rx_meta_reg <= RXD;
            rx_sync_reg <= rx_meta_reg;
            rx_prev_reg <= rx_sync_reg;
            if (ctrl_wr) begin
                rxie_reg <= DB[0];
                txie_reg <= DB[1];
            end
            irq_reg <= (rxie_reg & ~rx_empty) | (txie_reg & tx_empty & ~tx_busy);
        end
    end
    assign IRQ = irq_reg;

    // Sticky order: RXOVF, TXOVF, FE_any. Setting beats a STATUS-read clear.
    assign sticky_set[0] = rx_push & rx_full & ~rx_rd;
    assign sticky_set[1] = tx_wr & tx_full & ~tx_pop;
    assign sticky_set[2] = rx_push & rx_din[8];

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sticky
            logic flag_reg;
            always_ff @(posedge CLK) begin
                if (RST)                 flag_reg <= 1'b0;
                else if (sticky_set[gi]) flag_reg <= 1'b1;
                else if (st_rd)          flag_reg <= 1'b0;
            end
            assign sticky_bits[gi] = flag_reg;
        end
    endgenerate

    always_comb begin
        status             = '0;
        status[ST_RXNE]    = ~rx_empty;
        status[ST_RXFULL]  = rx_full;
        status[ST_TXFULL]  = tx_full;
        status[ST_TXEMPTY] = tx_empty;
        status[ST_TXBUSY]  = tx_busy;
        status[ST_RXOVF]   = sticky_bits[0];
        status[ST_TXOVF]   = sticky_bits[1];
        status[ST_FE_ANY]  = sticky_bits[2];
    end

    always_comb begin
        rd_data = '0;
        case (reg_ofs)
            OFS_RXDATA: if (!rx_empty) rd_data = {rx_dout[8], 17'b0, rx_dout[7:0]};
            OFS_STATUS: rd_data[7:0] = status;
            OFS_CTRL:   rd_data[1:0] = {txie_reg, rxie_reg};
            default:    rd_data = '0;
        endcase
    end
    assign DB = (~nIOR & addr_hit) ? rd_data : 'z;

    lvdc_byte_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(CLK), .srst(RST), .push(tx_wr), .pop(tx_pop), .din(DB[7:0]),
        .dout(tx_dout), .full(tx_full), .empty(tx_empty)
    );

    lvdc_byte_fifo #(.WIDTH(9), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(CLK), .srst(RST), .push(rx_push), .pop(rx_rd), .din(rx_din),
        .dout(rx_dout), .full(rx_full), .empty(rx_empty)
    );

    // ---------------- transmitter ----------------
    assign tx_tick = (tx_cnt_reg == BIT_LAST);
    assign tx_busy = (tx_state_reg != TX_IDLE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            tx_state_reg <= TX_IDLE;
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= '0;
            tx_shift_reg <= '0;
        end else begin
            tx_state_reg <= tx_state_next;
            if (tx_pop) begin
                tx_shift_reg <= tx_dout;
                tx_cnt_reg   <= '0;
                tx_bit_reg   <= '0;
            end else if (tx_busy) begin
                if (tx_tick) begin
                    tx_cnt_reg <= '0;
                    if (tx_state_reg == TX_DATA) begin
                        tx_shift_reg <= tx_shift_reg >> 1;
                        tx_bit_reg   <= tx_bit_reg + 1'b1;
                    end
                end else begin
                    tx_cnt_reg <= tx_cnt_reg + 1'b1;
                end
            end
        end
    end

    always_comb begin
        tx_state_next = tx_state_reg;
        case (tx_state_reg)
            TX_IDLE:  if (!tx_empty) tx_state_next = TX_START;
            TX_START: if (tx_tick) tx_state_next = TX_DATA;
            TX_DATA:  if (tx_tick && tx_bit_reg == 3'd7) tx_state_next = TX_STOP;
            TX_STOP:  if (tx_tick) tx_state_next = tx_empty ? TX_IDLE : TX_START;
            default:  tx_state_next = TX_IDLE;
        endcase
    end

    // Leaving STOP straight into START keeps back-to-back bytes gap-free.
    always_comb begin
        txd    = 1'b1;
        tx_pop = 1'b0;
        case (tx_state_reg)
            TX_IDLE:  tx_pop = ~tx_empty;
            TX_START: txd = 1'b0;
            TX_DATA:  txd = tx_shift_reg[0];
            TX_STOP:  tx_pop = tx_tick & ~tx_empty;
            default:  txd = 1'b1;
        endcase
    end
    assign TXD = txd;

    // ---------------- receiver ----------------
    assign rx_tick = (rx_cnt_reg == BIT_LAST);
    assign rx_half = (rx_cnt_reg == HALF_LAST);

    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_state_reg <= RX_IDLE;
            rx_cnt_reg   <= '0;
            rx_bit_reg   <= '0;
            rx_shift_reg <= '0;
        end else begin
            rx_state_reg <= rx_state_next;
            case (rx_state_reg)
                RX_IDLE: begin
                    rx_cnt_reg <= '0;
                    rx_bit_reg <= '0;
                end
                RX_START: rx_cnt_reg <= rx_half ? '0 : rx_cnt_reg + 1'b1;
                RX_DATA: begin
                    if (rx_tick) begin
                        rx_cnt_reg   <= '0;
                        rx_bit_reg   <= rx_bit_reg + 1'b1;
                        rx_shift_reg <= {rx_sync_reg, rx_shift_reg[7:1]};
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg + 1'b1;
                    end
                end
                RX_STOP: rx_cnt_reg <= rx_cnt_reg + 1'b1;
                default: rx_cnt_reg <= '0;
            endcase
        end
    end

    // After the half-bit wait in START, each full bit period lands mid-bit.
    always_comb begin
        rx_state_next = rx_state_reg;
        case (rx_state_reg)
            RX_IDLE:  if (rx_prev_reg && !rx_sync_reg) rx_state_next = RX_START;
            RX_START: if (rx_half) rx_state_next = rx_sync_reg ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_tick && rx_bit_reg == 3'd7) rx_state_next = RX_STOP;
            RX_STOP:  if (rx_tick) rx_state_next = RX_IDLE;
            default:  rx_state_next = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_push = (rx_state_reg == RX_STOP) && rx_tick;
        rx_din  = {~rx_sync_reg, rx_shift_reg};
    end

endmodule

// File: tb/tb_lvdc_pio_uart.sv
// Directed self-checking bench for lvdc_pio_uart (BASE 8'h40, 16 clks/bit, depth 8).
module tb_lvdc_pio_uart;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [12:0] I = '0;
    logic        nIOR = 1'b1;
    logic        nIOW = 1'b1;
    logic        RXD = 1'b1;
    wire         TXD;
    wire         IRQ;
    wire  [25:0] DB;
    logic [25:0] db_drv = '0;
    logic        db_oe = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [8:0] tx_q[$];

    assign DB = db_oe ? db_drv : 'z;

    always #5 CLK = ~CLK;

    lvdc_pio_uart #(.BASE_ADDR(8'h40), .CLKS_PER_BIT(16), .FIFO_DEPTH(8)) dut (
        .CLK(CLK), .RST(RST), .DB(DB), .I(I), .nIOR(nIOR), .nIOW(nIOW),
        .RXD(RXD), .TXD(TXD), .IRQ(IRQ)
    );

    // Serial decoder on TXD: queue gets {stop_bit, byte} per frame.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge CLK);
            if (!RST && TXD == 1'b0) begin
                repeat (8) @(negedge CLK);
                for (int k = 0; k < 8; k++) begin
                    repeat (16) @(negedge CLK);
                    b[k] = TXD;
                end
                repeat (16) @(negedge CLK);
                tx_q.push_back({TXD, b});
            end
        end
    end

    task automatic io_write(input logic [7:0] a, input logic [25:0] d, input int len);
        @(negedge CLK);
        I = {5'b0, a};
        db_drv = d;
        db_oe = 1'b1;
        nIOW = 1'b0;
        repeat (len) @(negedge CLK);
        nIOW = 1'b1;
        db_oe = 1'b0;
        $display("WR addr=%h data=%h len=%0d", a, d, len);
    endtask

    task automatic io_read(input logic [7:0] a, output logic [25:0] d);
        @(negedge CLK);
        I = {5'b0, a};
        nIOR = 1'b0;
        #1 d = DB;
        @(negedge CLK);
        nIOR = 1'b1;
        $display("RD addr=%h data=%h", a, d);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        @(negedge CLK);
        RXD = 1'b0;
        repeat (16) @(negedge CLK);
        for (int k = 0; k < 8; k++) begin
            RXD = b[k];
            repeat (16) @(negedge CLK);
        end
        RXD = stop_bit;
        repeat (16) @(negedge CLK);
        RXD = 1'b1;
        repeat (4) @(negedge CLK);
        $display("RX frame byte=%h stop=%b", b, stop_bit);
    endtask

    task automatic wait_q(input int n, input int limit);
        for (int c = 0; c < limit && tx_q.size() < n; c++) @(negedge CLK);
    endtask

    task automatic test_reset();
        logic [25:0] d;
        RST = 1'b1;
        I = 13'h042;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        checks++;
        if (TXD !== 1'b1) begin errors++; $display("FAIL reset_txd got %b expected 1", TXD); end
        checks++;
        if (IRQ !== 1'b0) begin errors++; $display("FAIL reset_irq got %b expected 0", IRQ); end
        checks++;
        if (!($isunknown(DB) || DB == 26'h0)) begin
            errors++; $display("FAIL reset_db_released got %h expected high-Z", DB);
        end
        io_read(8'h42, d);
        checks++;
        if (d !== 26'h0000008) begin errors++; $display("FAIL reset_status got %h expected %h", d, 26'h8); end
    endtask

    task automatic test_tx();
        logic [25:0] d;
        logic [8:0]  got;
        int n;
        tx_q.delete();
        @(negedge CLK);
        I = 13'h040;
        db_drv = 26'h00000A5;
        db_oe = 1'b1;
        nIOW = 1'b0;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
            if (n == 1) begin nIOW = 1'b1; db_oe = 1'b0; end
        end while (TXD !== 1'b0 && n < 10);
        checks++;
        if (n > 2) begin errors++; $display("FAIL tx_start_latency got %0d cycles expected <=2", n); end
        wait_q(1, 200);
        got = (tx_q.size() > 0) ? tx_q[0] : 9'h000;
        checks++;
        if (tx_q.size() != 1 || got !== 9'h1A5) begin
            errors++; $display("FAIL tx_frame_a5 got %h (n=%0d) expected 1a5", got, tx_q.size());
        end
        repeat (20) @(negedge CLK);
        io_read(8'h42, d);
        checks++;
        if (d !== 26'h0000008) begin errors++; $display("FAIL tx_done_status got %h expected 8", d); end
    endtask

    task automatic test_tx_overflow();
        logic [25:0] d;
        logic [8:0]  got;
        tx_q.delete();
        io_write(8'h40, 26'h0000000, 3);
        for (int v = 1; v <= 9; v++) io_write(8'h40, 26'(v), 1);
        io_read(8'h42, d);
        checks++;
        if (d !== 26'h0000054) begin errors++; $display("FAIL txovf_status got %h expected 54", d); end
        wait_q(10, 9 * 160 + 400);
        for (int i = 0; i < 9; i++) begin
            got = (i < tx_q.size()) ? tx_q[i] : 9'h000;
            checks++;
            if (got !== {1'b1, 8'(i)}) begin
                errors++; $display("FAIL txovf_byte%0d got %h expected %h", i, got, {1'b1, 8'(i)});
            end
        end
        checks++;
        if (tx_q.size() != 9) begin errors++; $display("FAIL txovf_count got %0d expected 9", tx_q.size()); end
        io_read(8'h42, d);
        checks++;
        if (d !== 26'h0000008) begin errors++; $display("FAIL txovf_cleared got %h expected 8", d); end
    endtask

    task automatic test_ctrl_irq();
        logic [25:0] d;
        io_write(8'h43, 26'h2, 1);
        repeat (2) @(negedge CLK);
        checks++;
        if (IRQ !== 1'b1) begin errors++; $display("FAIL txie_irq got %b expected 1", IRQ); end
        io_read(8'h43, d);
        checks++;
        if (d !== 26'h0000002) begin errors++; $display("FAIL ctrl_readback got %h expected 2", d); end
    endtask

    task automatic test_rx_irq();
        logic [25:0] d;
        io_write(8'h43, 26'h1, 1);
        repeat (2) @(negedge CLK);
        checks++;
        if (IRQ !== 1'b0) begin errors++; $display("FAIL rx_irq_idle got %b expected 0", IRQ); end
        send_rx(8'h3C, 1'b1);
        checks++;
        if (IRQ !== 1'b1) begin errors++; $display("FAIL rx_irq_set got %b expected 1", IRQ); end
        io_read(8'h42, d);
        checks++;
        if (d !== 26'h0000009) begin errors++; $display("FAIL rx_status_ne got %h expected 9", d); end
        io_read(8'h41, d);
        checks++;
        if (d !== 26'h000003C) begin errors++; $display("FAIL rx_data_3c got %h expected 3c", d); end
        repeat (2) @(negedge CLK);
        checks++;
        if (IRQ !== 1'b0) begin errors++; $display("FAIL rx_irq_clear got %b expected 0", IRQ); end
        io_read(8'h42, d);
        checks++;
        if (d !== 26'h0000008) begin errors++; $display("FAIL rx_status_empty got %h expected 8", d); end
    endtask

    task automatic test_rx_framing();
        logic [25:0] d;
        send_rx(8'h55, 1'b0);
        io_read(8'h41, d);
        checks++;
        if (d !== 26'h2000055) begin errors++; $display("FAIL fe_rxdata got %h expected 2000055", d); end
        io_read(8'h42, d);
        checks++;
        if (d !== 26'h0000088) begin errors++; $display("FAIL fe_status got %h expected 88", d); end
        io_read(8'h42, d);
        checks++;
        if (d !== 26'h0000008) begin errors++; $display("FAIL fe_cleared got %h expected 8", d); end
    endtask

    task automatic test_rx_overrun();
        logic [25:0] d;
        for (int i = 0; i < 9; i++) send_rx(8'h10 + 8'(i), 1'b1);
        io_read(8'h42, d);
        checks++;
        if (d !== 26'h000002B) begin errors++; $display("FAIL rxovf_status got %h expected 2b", d); end
        for (int i = 0; i < 8; i++) begin
            io_read(8'h41, d);
            checks++;
            if (d !== 26'h10 + 26'(i)) begin
                errors++; $display("FAIL rxovf_byte%0d got %h expected %h", i, d, 26'h10 + 26'(i));
            end
        end
        io_read(8'h42, d);
        checks++;
        if (d !== 26'h0000008) begin errors++; $display("FAIL rxovf_drained got %h expected 8", d); end
    endtask

    task automatic test_glitch();
        logic [25:0] d;
        @(negedge CLK);
        RXD = 1'b0;
        repeat (4) @(negedge CLK);
        RXD = 1'b1;
        repeat (200) @(negedge CLK);
        io_read(8'h42, d);
        checks++;
        if (d !== 26'h0000008) begin errors++; $display("FAIL glitch_status got %h expected 8", d); end
    endtask

    task automatic test_reset_mid_tx();
        logic [25:0] d;
        logic seen_low;
        io_write(8'h40, 26'h5A, 1);
        io_write(8'h40, 26'h33, 1);
        repeat (20) @(negedge CLK);
        checks++;
        if (TXD !== 1'b0) begin errors++; $display("FAIL mid_tx_bit0 got %b expected 0", TXD); end
        RST = 1'b1;
        @(negedge CLK);
        checks++;
        if (TXD !== 1'b1) begin errors++; $display("FAIL rst_txd got %b expected 1", TXD); end
        RST = 1'b0;
        io_read(8'h42, d);
        checks++;
        if (d !== 26'h0000008) begin errors++; $display("FAIL rst_status got %h expected 8", d); end
        io_read(8'h43, d);
        checks++;
        if (d !== 26'h0000000) begin errors++; $display("FAIL rst_ctrl got %h expected 0", d); end
        seen_low = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge CLK);
            if (TXD === 1'b0) seen_low = 1'b1;
        end
        checks++;
        if (seen_low !== 1'b0) begin errors++; $display("FAIL rst_tx_flushed got TXD low expected idle"); end
    endtask

    initial begin
        test_reset();
        test_tx();
        test_tx_overflow();
        test_ctrl_irq();
        test_rx_irq();
        test_rx_framing();
        test_rx_overrun();
        test_glitch();
        test_reset_mid_tx();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
